// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} rf_state_t;

  localparam int RF_NUM_REGS = 8;
  localparam int RF_DR_W     = 3;
  localparam int RF_DATA_W   = 16;

  typedef struct packed {
    logic                 ld;
    logic [RF_DR_W-1:0]   dr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps at N-1.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = 0; k < N; k++) begin
      // explicit wrap so non-power-of-two N never yields an unused code
      cand = (cand == IW'(N-1)) ? '0 : cand + 1'b1;
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 8x16 register file with post-reset clear sweep.
// Optional REGFILE_WB_LOCK_EN adds req_lock for burst re-grant to the last winner.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter  int NUM_REQ  = 3,
  parameter  int DATA_W   = RF_DATA_W,
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int DR_W     = $clog2(NUM_REGS),
  localparam int IW       = $clog2(NUM_REQ)
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DR_W-1:0]   req_dr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef REGFILE_WB_LOCK_EN
  input  logic [NUM_REQ-1:0]        req_lock,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      init_req,
  output logic                      init_busy,
  output logic                      LD_REG,
  output logic [DR_W-1:0]           DR,
  output logic [DATA_W-1:0]         bus,
  output logic [IW-1:0]             grant_id
);
  localparam logic [DR_W-1:0] LAST = DR_W'(NUM_REGS-1);

  rf_state_t         state, state_nxt;
  logic [DR_W-1:0]   cnt;
  logic [IW-1:0]     rr_ptr;
  logic [NUM_REQ-1:0] arb_gnt, sel_gnt;
  logic [IW-1:0]     arb_idx, sel_idx;
  logic              arb_any, sel_any, xfer;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

`ifdef REGFILE_WB_LOCK_EN
  logic hold;
  assign hold    = req_lock[rr_ptr] & req_valid[rr_ptr];
  assign sel_gnt = hold ? (NUM_REQ'(1) << rr_ptr) : arb_gnt;
  assign sel_idx = hold ? rr_ptr : arb_idx;
  assign sel_any = hold | arb_any;
`else
  assign sel_gnt = arb_gnt;
  assign sel_idx = arb_idx;
  assign sel_any = arb_any;
`endif

  assign req_ready = (state == RUN) ? sel_gnt : '0;
  assign xfer      = (state == RUN) && sel_any;
  assign init_busy = (state == CLEAR);

  always_comb begin
    state_nxt = state;
    case (state)
      CLEAR:   if (!init_req && cnt == LAST) state_nxt = RUN;
      RUN:     if (init_req) state_nxt = CLEAR;
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= CLEAR;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt      <= '0;
      LD_REG   <= 1'b0;
      DR       <= '0;
      bus      <= '0;
      rr_ptr   <= IW'(NUM_REQ-1);
      grant_id <= IW'(NUM_REQ-1);
    end else if (state == CLEAR) begin
      LD_REG <= 1'b1;
      DR     <= cnt;
      bus    <= '0;
      cnt    <= (init_req || cnt == LAST) ? '0 : cnt + 1'b1;
    end else begin
      LD_REG <= xfer;
      if (xfer) begin
        DR       <= req_dr[sel_idx*DR_W +: DR_W];
        bus      <= req_data[sel_idx*DATA_W +: DATA_W];
        rr_ptr   <= sel_idx;
        grant_id <= sel_idx;
      end
      if (init_req) cnt <= '0;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table vectors, corner sequences, random traffic vs model.
module tb_regfile_wb_arbiter;
  localparam int N = 3;
  localparam int W = 16;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*3-1:0] req_dr;
  logic [N*W-1:0] req_data;
  logic           init_req, init_busy, LD_REG;
  logic [2:0]     DR;
  logic [W-1:0]   bus;
  logic [1:0]     grant_id;
`ifdef REGFILE_WB_LOCK_EN
  logic [N-1:0]   req_lock;
`endif

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(W), .NUM_REGS(8)) dut (
    .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_dr(req_dr),
    .req_data(req_data),
`ifdef REGFILE_WB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready), .init_req(init_req), .init_busy(init_busy),
    .LD_REG(LD_REG), .DR(DR), .bus(bus), .grant_id(grant_id)
  );

  int checks = 0;
  int errors = 0;

  // reference model: sweep flag/counter, rr pointer, last write-port values
  bit m_clear, m_ld;
  int m_cnt, m_ptr, m_gid, m_dr, m_bus, m_win;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clear = 1; m_cnt = 0; m_ptr = N-1; m_gid = N-1;
    m_ld = 0; m_dr = 0; m_bus = 0; m_win = -1;
  endtask

  function automatic int pick();
    if (m_clear) return -1;
`ifdef REGFILE_WB_LOCK_EN
    if (req_valid[m_ptr] && req_lock[m_ptr]) return m_ptr;
`endif
    for (int k = 1; k <= N; k++)
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic cycle();
    int w;
    logic [N-1:0] er;
    #1;
    w = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("init_busy", init_busy, m_clear);
    @(posedge Clk);
    if (m_clear) begin
      m_ld = 1; m_dr = m_cnt; m_bus = 0;
      if (init_req) m_cnt = 0;
      else if (m_cnt == 7) begin m_cnt = 0; m_clear = 0; end
      else m_cnt++;
    end else begin
      if (w >= 0) begin
        m_ld = 1; m_dr = req_dr[3*w +: 3]; m_bus = req_data[W*w +: W];
        m_ptr = w; m_gid = w;
      end else m_ld = 0;
      if (init_req) begin m_clear = 1; m_cnt = 0; end
    end
    m_win = w;
    #1;
    chk("LD_REG", LD_REG, m_ld);
    chk("DR", DR, m_dr);
    chk("bus", bus, m_bus);
    chk("grant_id", grant_id, m_gid);
  endtask

  task automatic chk_reset_vals();
    chk("rst_LD_REG", LD_REG, 0);
    chk("rst_DR", DR, 0);
    chk("rst_bus", bus, 0);
    chk("rst_grant_id", grant_id, N-1);
    chk("rst_init_busy", init_busy, 1);
    chk("rst_req_ready", req_ready, 0);
  endtask

  typedef struct {
    logic [N-1:0] valid;
    logic [N-1:0] ready;
    logic         ld;
    logic [2:0]   dr;
    logic [W-1:0] data;
    logic [1:0]   gid;
  } vec_t;
  vec_t vt[9];

  initial begin
    vt[0] = '{3'b001, 3'b001, 1, 3'd3, 16'hBEEF, 2'd0};
    vt[1] = '{3'b010, 3'b010, 1, 3'd5, 16'h1111, 2'd1};
    vt[2] = '{3'b110, 3'b100, 1, 3'd6, 16'h2222, 2'd2};
    vt[3] = '{3'b010, 3'b010, 1, 3'd5, 16'h1111, 2'd1};
    vt[4] = '{3'b000, 3'b000, 0, 3'd5, 16'h1111, 2'd1};
    vt[5] = '{3'b111, 3'b100, 1, 3'd6, 16'h2222, 2'd2};
    vt[6] = '{3'b111, 3'b001, 1, 3'd3, 16'hBEEF, 2'd0};
    vt[7] = '{3'b111, 3'b010, 1, 3'd5, 16'h1111, 2'd1};
    vt[8] = '{3'b111, 3'b100, 1, 3'd6, 16'h2222, 2'd2};

    req_valid = '0; req_dr = '0; req_data = '0; init_req = 0;
`ifdef REGFILE_WB_LOCK_EN
    req_lock = '0;
`endif
    model_reset();
    #12;
    chk_reset_vals();
    Reset = 1;

    // post-reset sweep
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("sweep_dr", DR, i);
    end

    // table vectors
    req_dr   = {3'd6, 3'd5, 3'd3};
    req_data = {16'h2222, 16'h1111, 16'hBEEF};
    for (int i = 0; i < 9; i++) begin
      req_valid = vt[i].valid;
      #1;
      chk($sformatf("vec%0d_ready", i), req_ready, vt[i].ready);
      cycle();
      chk($sformatf("vec%0d_ld", i), LD_REG, vt[i].ld);
      chk($sformatf("vec%0d_dr", i), DR, vt[i].dr);
      chk($sformatf("vec%0d_bus", i), bus, vt[i].data);
      chk($sformatf("vec%0d_gid", i), grant_id, vt[i].gid);
    end

    // init_req on the edge that accepts requester 1
    req_valid = 3'b010; init_req = 1;
    cycle();
    chk("init_acc_dr", DR, 5);
    chk("init_acc_bus", bus, 16'h1111);
    init_req = 0; req_valid = 3'b111;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("resweep_dr", DR, i);
    end

    // reset during sweep cycle 4
    init_req = 1;
    cycle();
    init_req = 0;
    repeat (4) cycle();
    #2 Reset = 0;
    #1 chk_reset_vals();
    model_reset();
    #2 Reset = 1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("rst_sweep_dr", DR, i);
    end

    // random traffic, payloads held until accepted
    for (int c = 0; c < 400; c++) begin
      init_req = ($urandom_range(0, 49) == 0);
`ifdef REGFILE_WB_LOCK_EN
      req_lock = N'($urandom);
`endif
      cycle();
      for (int r = 0; r < N; r++) begin
        if (r == m_win || (!req_valid[r] && $urandom_range(0, 9) < 4)) begin
          req_valid[r] = $urandom_range(0, 1);
          req_dr[3*r +: 3] = 3'($urandom);
          req_data[W*r +: W] = W'($urandom);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 8x16 register file (load enable, 3-bit destination, 16-bit bus) among NUM_REQ writeback requesters, e.g. ALU, memory load and debug.
- Round-robin arbitration with a valid/ready handshake per requester.
- A clear sequencer zeroes R0..R7 after reset and on demand.
- Sits between the execute/memory stages and the register file.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
DATA_W, 16, register/bus data width
NUM_REGS, 8, registers in file; DR width = $clog2(NUM_REGS)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester write request
req_dr  in  NUM_REQ*3  flattened destination indices, requester i at [3i+2:3i]
req_data  in  NUM_REQ*DATA_W  flattened write data, requester i at [DATA_W*i+:DATA_W]
req_ready  out  NUM_REQ  one-hot grant, combinational
init_req  in  1  pulse: start clear sweep
init_busy  out  1  high while clear sweep active
LD_REG  out  1  register-file load enable, registered
DR  out  3  register-file destination, registered
bus  out  DATA_W  register-file write data, registered
grant_id  out  $clog2(NUM_REQ)  index of last granted requester, registered

Behaviour:
- Reset asserted (low) forces, asynchronously:
  - state=CLEAR, clear counter=0
  - LD_REG=0, DR=0, bus=0, grant_id=NUM_REQ-1, rr pointer=NUM_REQ-1
  - init_busy=1
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle registers LD_REG=1, DR=counter, bus=0; counter increments.
  - After DR=7 is issued, counter wraps to 0 and state goes to RUN.
  - Sweep is exactly NUM_REGS cycles of LD_REG.
  - req_ready=0 throughout; init_busy=1.
- RUN:
  - init_busy=0.
  - Grant search starts at rr pointer+1, wrapping modulo NUM_REQ; first requester with req_valid=1 wins.
  - req_ready is one-hot for the winner and all-zero when no request is valid.
  - Transfer occurs on an edge where req_valid[i]&req_ready[i]=1. On that edge:
    - LD_REG<=1, DR<=req_dr[i], bus<=req_data[i]
    - rr pointer<=i, grant_id<=i
  - The register file captures the write on the next edge: 1-cycle latency from acceptance to the write-port drive, 2 edges to the register update.
  - No transfer on an edge means LD_REG<=0 and DR/bus hold their last values.
  - Sustained throughput is one write per cycle; a requester held valid with others idle is granted every cycle.
- Requester rule: req_valid, req_dr and req_data stay stable until accepted. The arbiter does not check this.
- init_req:
  - init_req=1 in RUN: next state CLEAR, counter=0. Any transfer accepted on that same edge still completes (its LD_REG cycle precedes the sweep).
  - init_req=1 during CLEAR restarts the counter at 0.
- Simultaneous requests: exactly one grant per cycle. The others wait with no data loss.
- The rr pointer is unaffected by CLEAR.
- Reset mid-sweep or mid-transfer: asynchronous clear to the reset values above. The pending write is dropped, and the sweep restarts after reset release.
- NUM_REQ not a power of two: pointer wrap is explicit (NUM_REQ-1 -> 0). Unused grant_id codes are never produced.

Optional Feature:
- Macro: REGFILE_WB_LOCK_EN. Adds input req_lock (NUM_REQ bits).
- With macro defined: if the last-granted requester i has req_lock[i]=1 and req_valid[i]=1, it is re-granted regardless of round-robin (burst writes). Lock is ignored in CLEAR.
- Without macro: port absent; pure round-robin.

Decomposition:
- Shared package regfile_pkg holds:
  - the state enum (CLEAR, RUN)
  - constants RF_NUM_REGS=8, RF_DR_W=3, RF_DATA_W=16
  - typedef rf_wr_t {logic ld; logic [2:0] dr; logic [15:0] data}
- One natural sub-module: rr_arbiter, a parameterised combinational round-robin grant from request vector and pointer, returning one-hot grant and index.

Test Plan:
- Reset release, no requests -> LD_REG=1 for 8 consecutive cycles with DR=0..7, bus=0; init_busy falls the cycle after DR=7; req_ready=0 throughout.
- After clear, req_valid=3'b001, req_dr[0]=3, data 16'hBEEF -> req_ready=001 same cycle; next cycle LD_REG=1, DR=3, bus=BEEF, grant_id=0.
- All three valid continuously after reset -> grant order 0,1,2,0,1,2; LD_REG high every cycle; no request starved.
- req_valid=3'b110, pointer at 1 -> requester 2 granted first, then 1.
- init_req pulsed while requester 1 is being accepted -> requester 1's write appears first, then an 8-cycle sweep; req_ready=0 during the sweep.
- Reset driven low at sweep cycle 4 -> outputs zero immediately (async); after release the sweep restarts at DR=0.
